// File: rtl/sort_sched.sv
// Sample-buffer write pointer and sort launch scheduler: fills the buffer, then
// launches one sort per HOP new samples and arbitrates buffer port B.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_FILL     | buffer not yet full; counting first DEPTH samples
// S_WAIT_HOP | idle between sorts; launches when a hop is pending and port B is free
// S_LAUNCH   | one-cycle sort_dv pulse, window start captured in new_cnt
// S_SORTING  | sorter owns port B; watchdog running
module sort_sched #(
    parameter int DEPTH   = 1503,
    parameter int HOP     = 500,
    parameter int TIMEOUT = 8191
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_dv,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic        sort_dv,
    output logic [11:0] new_cnt,
    input  logic        sort_done,
    input  logic [10:0] sort_addr,
    input  logic        fd_req,
    input  logic [10:0] fd_addr,
    output logic        fd_gnt,
    output logic [10:0] ram_addr_b,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    output logic [15:0] win_cnt
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int HOP_W  = $clog2(HOP + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [10:0]       PTR_LAST  = 11'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
    localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_WAIT_HOP = 2'd1,
        S_LAUNCH   = 2'd2,
        S_SORTING  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [10:0]       wr_ptr;
    logic [10:0]       wr_ptr_nxt;
    logic [FILL_W-1:0] fill_cnt;
    logic [HOP_W-1:0]  hop_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              pending;
    logic              fill_done;
    logic              hop_active;
    logic              hop_hit;
    logic              sort_ok;
    logic              wd_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        if (sample_dv) begin
            wr_ptr_nxt = (wr_ptr == PTR_LAST) ? 11'd0 : wr_ptr + 11'd1;
        end

        fill_done  = (state == S_FILL) && sample_dv && (fill_cnt == FILL_LAST);
        hop_active = (state == S_WAIT_HOP) || (state == S_SORTING);
        hop_hit    = hop_active && sample_dv && (hop_cnt == HOP_LAST);
        sort_ok    = (state == S_SORTING) && sort_done;
        // A sort_done arriving on the expiry cycle takes precedence over the abort.
        wd_expire  = (state == S_SORTING) && !sort_done && (wd_cnt == WD_LAST);

        case (state)
            S_FILL: begin
                if (fill_done) begin
                    state_nxt = fd_req ? S_WAIT_HOP : S_LAUNCH;
                end
            end
            S_WAIT_HOP: begin
                if (pending && !fd_req) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_nxt = S_SORTING;
            end
            S_SORTING: begin
                if (sort_ok || wd_expire) begin
                    state_nxt = S_WAIT_HOP;
                end
            end
            default: begin
                state_nxt = S_FILL;
            end
        endcase

        wr_en      = sample_dv;
        wr_addr    = wr_ptr;
        sort_dv    = (state == S_LAUNCH);
        busy       = (state == S_LAUNCH) || (state == S_SORTING);
        fd_gnt     = 1'b0;
        ram_addr_b = sort_addr;
        if ((state == S_FILL) || (state == S_WAIT_HOP)) begin
            fd_gnt     = fd_req;
            ram_addr_b = fd_req ? fd_addr : sort_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            hop_cnt     <= '0;
            wd_cnt      <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            win_cnt     <= '0;
            new_cnt     <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;

            if ((state == S_FILL) && sample_dv) begin
                fill_cnt <= fill_done ? '0 : fill_cnt + 1'b1;
            end

            if (hop_active && sample_dv) begin
                hop_cnt <= hop_hit ? '0 : hop_cnt + 1'b1;
            end

            // Buffer filled while the secondary reader holds port B: defer as a pending launch.
            if (state == S_LAUNCH) begin
                pending <= 1'b0;
            end else if (hop_hit || (fill_done && fd_req)) begin
                pending <= 1'b1;
            end

            overrun <= hop_hit && pending && !overrun;

            if ((state == S_SORTING) && (state_nxt == S_SORTING)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end

            timeout_err <= wd_expire;

            if (sort_ok) begin
                win_cnt <= win_cnt + 16'd1;
            end

            // Capture the pointer the launch cycle will present, so new_cnt is valid with sort_dv.
            if (state_nxt == S_LAUNCH) begin
                new_cnt <= {1'b0, wr_ptr_nxt};
            end
        end
    end

endmodule

// File: doc/sort_sched.md
SORT_SCHED -- requirements
Module: sort_sched

Interface
REQ-001 Parameter DEPTH, default 1503: sample buffer entries; write pointer wraps DEPTH-1 -> 0.
REQ-002 Parameter HOP, default 500: new samples between successive sort launches.
REQ-003 Parameter TIMEOUT, default 8191: maximum cycles in SORTING before abort.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_dv  in  1  one new sample this cycle, written at wr_addr.
REQ-007 wr_en  out  1  buffer port A write enable, equal to sample_dv (combinational).
REQ-008 wr_addr  out  11  buffer port A address, equal to current write pointer.
REQ-009 sort_dv  out  1  one-cycle sort launch pulse to the time-domain sorter.
REQ-010 new_cnt  out  12  oldest-sample index for the launched window, valid with and held after sort_dv.
REQ-011 sort_done  in  1  sorter completion pulse.
REQ-012 sort_addr  in  11  sorter read address.
REQ-013 fd_req  in  1  secondary (frequency-domain) reader requests buffer port B.
REQ-014 fd_addr  in  11  secondary reader address.
REQ-015 fd_gnt  out  1  port B granted to secondary reader.
REQ-016 ram_addr_b  out  11  buffer port B address (combinational mux).
REQ-017 busy  out  1  high in LAUNCH or SORTING.
REQ-018 overrun  out  1  one-cycle pulse: hop boundary reached while a launch already pending.
REQ-019 timeout_err  out  1  one-cycle pulse on sort abort.
REQ-020 win_cnt  out  16  completed sorts, wraps at 65535 -> 0.

Function
REQ-021 States: FILL, WAIT_HOP, LAUNCH, SORTING.
REQ-022 Write pointer increments on every sample_dv in all states; DEPTH-1 + sample_dv -> 0.
REQ-023 FILL: count sample_dv; after DEPTH samples -> LAUNCH request set (buffer full).
REQ-024 WAIT_HOP/SORTING: hop counter counts sample_dv; on reaching HOP, clear to 0 and set pending.
REQ-025 Hop boundary while pending already set: pending stays 1, overrun pulses next cycle.
REQ-026 WAIT_HOP -> LAUNCH when pending=1 and fd_req=0; pending with fd_req=1 waits (secondary reader finishes first).
REQ-027 LAUNCH (one cycle): sort_dv=1, new_cnt = write pointer value before any same-cycle increment, pending cleared, -> SORTING.
REQ-028 SORTING: ram_addr_b = sort_addr, fd_gnt=0 regardless of fd_req; watchdog counts cycles from entry.
REQ-029 SORTING + sort_done -> WAIT_HOP, win_cnt+1, watchdog cleared.
REQ-030 Watchdog reaching TIMEOUT without sort_done: timeout_err pulse, -> WAIT_HOP, win_cnt unchanged; sort_done in same cycle wins (counts as done, no error).
REQ-031 sort_done outside SORTING ignored.
REQ-032 FILL/WAIT_HOP: fd_gnt = fd_req, ram_addr_b = fd_req ? fd_addr : sort_addr.
REQ-033 sort_dv, overrun, timeout_err never high more than one consecutive cycle.

Reset
REQ-034 reset=1 at clock edge: state FILL; pointer, fill/hop/watchdog counters, pending, win_cnt, new_cnt = 0; sort_dv, overrun, timeout_err = 0.
REQ-035 reset mid-SORTING aborts without timeout_err; later sort_done ignored until next LAUNCH.
REQ-036 sample_dv during reset not written-counted (pointer stays 0); wr_en still follows sample_dv.

Verification (DEPTH=8, HOP=3, TIMEOUT=20)
REQ-037 Reset, 8 sample_dv back-to-back -> wr_addr 0..7 then 0, single sort_dv with new_cnt=0 one cycle after 8th sample.
REQ-038 sort_done 5 cycles after launch, 3 more samples -> win_cnt=1, second sort_dv with new_cnt=3.
REQ-039 Hold sort_done low 20 cycles in SORTING -> timeout_err pulse cycle 20, win_cnt unchanged, state WAIT_HOP.
REQ-040 6 samples during one SORTING -> one overrun pulse, exactly one launch after sort_done.
REQ-041 fd_req=1 when pending set -> no sort_dv, fd_gnt=1, ram_addr_b=fd_addr; fd_req drop -> sort_dv next cycle; fd_req during SORTING -> fd_gnt=0, ram_addr_b=sort_addr.
REQ-042 reset asserted 2 cycles after sort_dv -> all outputs zero, FILL; subsequent sort_done produces no win_cnt change.
